// File: rtl/render_sequencer.sv
// Frame controller: loads 8 object records into a two-set cache, then scans every sampled pixel
// with an A/B beat pair, drains the render pipeline and pulses frame done. Optional RENDER_SEQ_STALL_EN adds stall_in.
module render_sequencer #(
  parameter int unsigned H_PIXELS     = 1280,
  parameter int unsigned V_PIXELS     = 720,
  parameter int unsigned H_STEP       = 2,
  parameter int unsigned V_STEP       = 2,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          frame_start_in,
`ifdef RENDER_SEQ_STALL_EN
  input  logic          stall_in,
`endif
  output logic [6:0]    obj_addr_out,
  output logic          obj_rd_en_out,
  input  logic [82:0]   obj_data_in,
  output logic          render_rst_out,
  output logic          render_valid_out,
  output logic [3:0]    is_static_out,
  output logic [7:0]    id_bits_out,
  output logic [191:0]  params_out,
  output logic [63:0]   pos_x_out,
  output logic [63:0]   pos_y_out,
  output logic [10:0]   hcount_out,
  output logic [9:0]    vcount_out,
  output logic          busy_out,
  output logic          frame_done_out
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REC_W = 83;
  localparam int unsigned LANES = 4;
  localparam int unsigned SLOTS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(READ_LATENCY + SLOTS - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(READ_LATENCY + SLOTS);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REC_W-1:0] cache_q [SLOTS];
  logic [REC_W-1:0] bus_rec [LANES];
  logic             cache_we;
  logic [2:0]       cache_idx;
  logic             bus_ld, bus_phase;
  logic             beat_q, beat_d;
  logic             phase_q, phase_d;
  logic [10:0]      h_d;
  logic [9:0]       v_d;
  logic [6:0]       addr_d;
  logic             rd_en_d, rrst_d, busy_d, done_d;
  logic             stall;
  logic             last_col, last_row;

`ifdef RENDER_SEQ_STALL_EN
  assign stall            = stall_in;
  assign render_valid_out = beat_q & ~stall_in;
`else
  assign stall            = 1'b0;
  assign render_valid_out = beat_q;
`endif

  // 12-bit compares so hcount/vcount + step never wraps
  assign last_col = (12'(hcount_out) + 12'(H_STEP)) >= 12'(H_PIXELS);
  assign last_row = (12'(vcount_out) + 12'(V_STEP)) >= 12'(V_PIXELS);

  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      bus_rec[i] = cache_q[{bus_phase, 2'(i)}];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = '0;
    rd_en_d   = 1'b0;
    rrst_d    = 1'b0;
    beat_d    = 1'b0;
    phase_d   = 1'b0;
    h_d       = '0;
    v_d       = '0;
    busy_d    = busy_out;
    done_d    = 1'b0;
    cache_we  = 1'b0;
    cache_idx = 3'(cnt_q - CAP_FIRST);
    bus_ld    = 1'b0;
    bus_phase = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (frame_start_in) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          rd_en_d = 1'b1;
          addr_d  = 7'(BASE_ADDR);
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < RD_LAST) begin
          rd_en_d = 1'b1;
          addr_d  = 7'(BASE_ADDR) + 7'(cnt_q) + 7'd1;
        end
        cache_we = (cnt_q >= CAP_FIRST) && (cnt_q <= CAP_LAST);
        rrst_d   = (cnt_q == CAP_LAST);
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          beat_d  = 1'b1;
          bus_ld  = 1'b1;
        end
      end
      ST_SCAN: begin
        beat_d  = 1'b1;
        phase_d = phase_q;
        h_d     = hcount_out;
        v_d     = vcount_out;
        if (!stall) begin
          bus_ld = 1'b1;
          if (!phase_q) begin
            phase_d   = 1'b1;
            bus_phase = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (!last_col) begin
              h_d = hcount_out + 11'(H_STEP);
            end else if (!last_row) begin
              h_d = '0;
              v_d = vcount_out + 10'(V_STEP);
            end else begin
              // trailing set-A beat at the last pixel flushes the final B result
              state_d = ST_DRAIN;
              cnt_d   = '0;
            end
          end
        end
      end
      ST_DRAIN: begin
        h_d = hcount_out;
        v_d = vcount_out;
        if ((cnt_q == '0) && stall) begin
          beat_d = 1'b1;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          h_d     = '0;
          v_d     = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      beat_q         <= 1'b0;
      phase_q        <= 1'b0;
      obj_addr_out   <= '0;
      obj_rd_en_out  <= 1'b0;
      render_rst_out <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      is_static_out  <= '0;
      id_bits_out    <= '0;
      params_out     <= '0;
      pos_x_out      <= '0;
      pos_y_out      <= '0;
      for (int k = 0; k < int'(SLOTS); k++) begin
        cache_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      beat_q         <= beat_d;
      phase_q        <= phase_d;
      obj_addr_out   <= addr_d;
      obj_rd_en_out  <= rd_en_d;
      render_rst_out <= rrst_d;
      hcount_out     <= h_d;
      vcount_out     <= v_d;
      busy_out       <= busy_d;
      frame_done_out <= done_d;
      if (cache_we) begin
        cache_q[cache_idx] <= obj_data_in;
      end
      // object bus only changes when a new beat is presented
      if (bus_ld) begin
        for (int i = 0; i < int'(LANES); i++) begin
          is_static_out[i]          <= bus_rec[i][82];
          id_bits_out[i*2 +: 2]     <= bus_rec[i][81:80];
          params_out[i*48 +: 48]    <= bus_rec[i][79:32];
          pos_x_out[i*16 +: 16]     <= bus_rec[i][31:16];
          pos_y_out[i*16 +: 16]     <= bus_rec[i][15:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_render_sequencer.sv
// Directed bench for render_sequencer: 8x4 and 7x3 frames, cache lane mapping, ignored starts,
// mid-frame reset and (with RENDER_SEQ_STALL_EN) a three-cycle stall on a B beat.
module tb_render_sequencer;

  typedef struct packed {
    logic         rd;
    logic [6:0]   addr;
    logic         rrst;
    logic         valid;
    logic [3:0]   st;
    logic [7:0]   id;
    logic [191:0] pr;
    logic [63:0]  px;
    logic [63:0]  py;
    logic [10:0]  h;
    logic [9:0]   v;
    logic         busy;
    logic         done;
  } obs_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, frame_start_in, fs2_in;
`ifdef RENDER_SEQ_STALL_EN
  logic stall_drv;
  int   st_from = -1;
  int   st_len  = 0;
`endif

  logic [6:0]   d_addr, e_addr, d_p0, d_p1, e_p0, e_p1;
  logic         d_rd, d_rrst, d_valid, d_busy, d_done;
  logic         e_rd, e_rrst, e_valid, e_busy, e_done;
  logic [82:0]  d_data, e_data;
  logic [3:0]   d_st, e_st;
  logic [7:0]   d_id, e_id;
  logic [191:0] d_pr, e_pr;
  logic [63:0]  d_px, d_py, e_px, e_py;
  logic [10:0]  d_h, e_h;
  logic [9:0]   d_v, e_v;

  obs_t log_q [0:79];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Object k record: distinct fields per slot so any lane/set swap shows
  function automatic logic [82:0] rec(input logic [6:0] a);
    logic [2:0] k;
    k = a[2:0];
    rec = {k[2] ^ k[0], 2'b01, 40'h5A5A_C3C3_00, 5'd0, k, 13'h020, k, 13'h040, ~k};
  endfunction

  function automatic void exp_lanes(input int p, output logic [3:0] st, output logic [7:0] id,
                                    output logic [191:0] pr, output logic [63:0] px,
                                    output logic [63:0] py);
    logic [82:0] r;
    for (int i = 0; i < 4; i++) begin
      r = rec(7'(4 * p + i));
      st[i]          = r[82];
      id[i*2 +: 2]   = r[81:80];
      pr[i*48 +: 48] = r[79:32];
      px[i*16 +: 16] = r[31:16];
      py[i*16 +: 16] = r[15:0];
    end
  endfunction

  // Expected pixel of beat b for the 8x4 / 7x3 frames (4 columns, 2 rows, then trailing beat)
  function automatic int exp_h(input int b);
    exp_h = (b >= 16) ? 6 : 2 * ((b / 2) % 4);
  endfunction
  function automatic int exp_v(input int b);
    exp_v = (b >= 16) ? 2 : 2 * ((b / 2) / 4);
  endfunction

  render_sequencer #(.H_PIXELS(8), .V_PIXELS(4), .H_STEP(2), .V_STEP(2), .BASE_ADDR(0),
                     .READ_LATENCY(2), .DRAIN_CYCLES(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
`ifdef RENDER_SEQ_STALL_EN
    .stall_in(stall_drv),
`endif
    .obj_addr_out(d_addr), .obj_rd_en_out(d_rd), .obj_data_in(d_data),
    .render_rst_out(d_rrst), .render_valid_out(d_valid), .is_static_out(d_st),
    .id_bits_out(d_id), .params_out(d_pr), .pos_x_out(d_px), .pos_y_out(d_py),
    .hcount_out(d_h), .vcount_out(d_v), .busy_out(d_busy), .frame_done_out(d_done)
  );

  render_sequencer #(.H_PIXELS(7), .V_PIXELS(3), .H_STEP(2), .V_STEP(2), .BASE_ADDR(0),
                     .READ_LATENCY(2), .DRAIN_CYCLES(8)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(fs2_in),
`ifdef RENDER_SEQ_STALL_EN
    .stall_in(1'b0),
`endif
    .obj_addr_out(e_addr), .obj_rd_en_out(e_rd), .obj_data_in(e_data),
    .render_rst_out(e_rrst), .render_valid_out(e_valid), .is_static_out(e_st),
    .id_bits_out(e_id), .params_out(e_pr), .pos_x_out(e_px), .pos_y_out(e_py),
    .hcount_out(e_h), .vcount_out(e_v), .busy_out(e_busy), .frame_done_out(e_done)
  );

  // Object storage with two-cycle read latency
  always @(posedge clk_in) begin
    d_p0 <= d_addr;
    d_p1 <= d_p0;
    e_p0 <= e_addr;
    e_p1 <= e_p0;
  end
  assign d_data = rec(d_p1);
  assign e_data = rec(e_p1);

  // Drive dut for ncyc cycles (inputs just after posedge) and log its outputs at each negedge
  task automatic capture(input int ncyc, input int fsa, input int fsb, input int fsc, input int rst_cyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_in);
      #1;
      frame_start_in = (c == fsa) || (c == fsb) || (c == fsc);
      rst_in         = (c != rst_cyc);
`ifdef RENDER_SEQ_STALL_EN
      stall_drv = (c >= st_from) && (c < st_from + st_len);
`endif
      @(negedge clk_in);
      log_q[c] = {d_rd, d_addr, d_rrst, d_valid, d_st, d_id, d_pr, d_px, d_py, d_h, d_v, d_busy, d_done};
    end
    frame_start_in = 1'b0;
    rst_in         = 1'b1;
`ifdef RENDER_SEQ_STALL_EN
    stall_drv = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    frame_start_in = 1'b0;
    fs2_in = 1'b0;
`ifdef RENDER_SEQ_STALL_EN
    stall_drv = 1'b0;
`endif
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    n_checks++;
    if ({d_rd, d_addr, d_rrst, d_valid, d_st, d_id, d_pr, d_px, d_py, d_h, d_v, d_busy, d_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b valid=%0b h=%0d px=%h, want all zero", d_busy, d_valid, d_h, d_px);
    end
    n_checks++;
    if ({e_rd, e_valid, e_busy, e_done, e_h, e_v} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs2: got rd=%0b valid=%0b busy=%0b, want 0", e_rd, e_valid, e_busy);
    end
    rst_in = 1'b1;
  endtask

  task automatic test_basic_frame();
    int n;
    capture(45, 0, -1, -1, -1);
    n_checks++;
    if (log_q[0].busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_idle: got %0b want 0", log_q[0].busy);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (log_q[1 + k].rd !== 1'b1 || log_q[1 + k].addr !== 7'(k)) begin
        n_fail++; $display("FAIL basic_read%0d: got rd=%0b addr=%0d want rd=1 addr=%0d", k, log_q[1 + k].rd, log_q[1 + k].addr, k);
      end
    end
    n = 0;
    for (int c = 0; c < 45; c++) if (log_q[c].rd === 1'b1) n++;
    n_checks++;
    if (n != 8) begin n_fail++; $display("FAIL basic_read_count: got %0d want 8", n); end
    n = 0;
    for (int c = 0; c < 45; c++) if (log_q[c].rrst === 1'b1) n++;
    n_checks++;
    if (n != 1 || log_q[11].rrst !== 1'b1) begin
      n_fail++; $display("FAIL basic_render_rst: got count=%0d at11=%0b want 1,1", n, log_q[11].rrst);
    end
    for (int b = 0; b < 17; b++) begin
      n_checks++;
      if (log_q[12 + b].valid !== 1'b1 || log_q[12 + b].h !== 11'(exp_h(b)) || log_q[12 + b].v !== 10'(exp_v(b))) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got valid=%0b h=%0d v=%0d want 1 h=%0d v=%0d", b,
                 log_q[12 + b].valid, log_q[12 + b].h, log_q[12 + b].v, exp_h(b), exp_v(b));
      end
    end
    n = 0;
    for (int c = 0; c < 45; c++) if (log_q[c].valid === 1'b1) n++;
    n_checks++;
    if (n != 17) begin n_fail++; $display("FAIL basic_beat_count: got %0d want 17", n); end
    n = 0;
    for (int c = 0; c < 45; c++) if (log_q[c].done === 1'b1) n++;
    n_checks++;
    if (n != 1 || log_q[37].done !== 1'b1 || log_q[37].busy !== 1'b0 || log_q[36].busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: got count=%0d done37=%0b busy37=%0b busy36=%0b want 1,1,0,1",
               n, log_q[37].done, log_q[37].busy, log_q[36].busy);
    end
    n_checks++;
    if (log_q[38].h !== 11'd0 || log_q[38].v !== 10'd0 || log_q[38].busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle_after: got h=%0d v=%0d busy=%0b want 0,0,0", log_q[38].h, log_q[38].v, log_q[38].busy);
    end
  endtask

  task automatic test_cache_mapping();
    logic [3:0] st; logic [7:0] id; logic [191:0] pr; logic [63:0] px, py;
    capture(45, 0, -1, -1, -1);
    for (int b = 0; b < 17; b++) begin
      exp_lanes((b == 16) ? 0 : (b % 2), st, id, pr, px, py);
      n_checks++;
      if ({log_q[12 + b].st, log_q[12 + b].id, log_q[12 + b].pr, log_q[12 + b].px, log_q[12 + b].py} !== {st, id, pr, px, py}) begin
        n_fail++;
        $display("FAIL map_beat%0d: got st=%h id=%h px=%h py=%h want st=%h id=%h px=%h py=%h", b,
                 log_q[12 + b].st, log_q[12 + b].id, log_q[12 + b].px, log_q[12 + b].py, st, id, px, py);
      end
    end
    exp_lanes(0, st, id, pr, px, py);
    n_checks++;
    if (log_q[33].valid !== 1'b0 || log_q[33].px !== px || log_q[33].pr !== pr) begin
      n_fail++; $display("FAIL map_hold: got valid=%0b px=%h want 0 px=%h", log_q[33].valid, log_q[33].px, px);
    end
  endtask

  task automatic test_ignore_start();
    int n_done, n_bad, n_rd, n_val;
    capture(50, 0, 15, 37, -1);
    n_done = 0; n_bad = 0; n_rd = 0; n_val = 0;
    for (int c = 0; c < 50; c++) begin
      if (log_q[c].done === 1'b1) n_done++;
      if (log_q[c].rd === 1'b1) n_rd++;
      if (log_q[c].valid === 1'b1) n_val++;
      if (log_q[c].busy !== ((c >= 1) && (c <= 36))) n_bad++;
    end
    n_checks++;
    if (n_done != 1 || log_q[37].done !== 1'b1) begin
      n_fail++; $display("FAIL ignore_done: got count=%0d done37=%0b want 1,1", n_done, log_q[37].done);
    end
    n_checks++;
    if (n_bad != 0) begin n_fail++; $display("FAIL ignore_busy: got %0d bad busy cycles want 0", n_bad); end
    n_checks++;
    if (n_rd != 8 || n_val != 17) begin
      n_fail++; $display("FAIL ignore_counts: got reads=%0d beats=%0d want 8,17", n_rd, n_val);
    end
  endtask

  task automatic test_reset_midframe();
    int n_done, n_val;
    logic [3:0] st; logic [7:0] id; logic [191:0] pr; logic [63:0] px, py;
    capture(70, 0, 20, -1, 17);
    n_checks++;
    if (log_q[17].valid !== 1'b1 || log_q[17].h !== 11'd4 || log_q[17].v !== 10'd0) begin
      n_fail++; $display("FAIL rst_beat5: got valid=%0b h=%0d v=%0d want 1,4,0", log_q[17].valid, log_q[17].h, log_q[17].v);
    end
    n_checks++;
    if (log_q[18] !== '0) begin
      n_fail++; $display("FAIL rst_zero: got busy=%0b valid=%0b h=%0d px=%h want all zero",
                         log_q[18].busy, log_q[18].valid, log_q[18].h, log_q[18].px);
    end
    n_done = 0; n_val = 0;
    for (int c = 0; c < 57; c++) if (log_q[c].done === 1'b1) n_done++;
    for (int c = 19; c < 70; c++) if (log_q[c].valid === 1'b1) n_val++;
    n_checks++;
    if (n_done != 0 || log_q[57].done !== 1'b1) begin
      n_fail++; $display("FAIL rst_done: got early=%0d done57=%0b want 0,1", n_done, log_q[57].done);
    end
    n_checks++;
    if (n_val != 17) begin n_fail++; $display("FAIL rst_beat_count: got %0d want 17", n_val); end
    exp_lanes(0, st, id, pr, px, py);
    n_checks++;
    if (log_q[32].valid !== 1'b1 || log_q[32].px !== px || log_q[31].valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_first_beat: got valid=%0b px=%h want 1 px=%h", log_q[32].valid, log_q[32].px, px);
    end
    for (int b = 0; b < 17; b++) begin
      n_checks++;
      if (log_q[32 + b].h !== 11'(exp_h(b)) || log_q[32 + b].v !== 10'(exp_v(b))) begin
        n_fail++; $display("FAIL rst_beat%0d: got h=%0d v=%0d want h=%0d v=%0d", b,
                           log_q[32 + b].h, log_q[32 + b].v, exp_h(b), exp_v(b));
      end
    end
  endtask

  task automatic test_nondivisible();
    int b, done_at;
    b = 0; done_at = -1;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk_in);
      #1;
      fs2_in = (c == 0);
      @(negedge clk_in);
      if (e_valid === 1'b1) begin
        n_checks++;
        if (e_h !== 11'(exp_h(b)) || e_v !== 10'(exp_v(b))) begin
          n_fail++; $display("FAIL nondiv_beat%0d: got h=%0d v=%0d want h=%0d v=%0d", b, e_h, e_v, exp_h(b), exp_v(b));
        end
        b++;
      end
      if (e_done === 1'b1 && done_at < 0) done_at = c;
    end
    fs2_in = 1'b0;
    n_checks++;
    if (b != 17) begin n_fail++; $display("FAIL nondiv_beat_count: got %0d want 17", b); end
    n_checks++;
    if (done_at != 37) begin n_fail++; $display("FAIL nondiv_done: got cycle %0d want 37", done_at); end
  endtask

`ifdef RENDER_SEQ_STALL_EN
  task automatic test_stall();
    int n_val;
    logic [3:0] st; logic [7:0] id; logic [191:0] pr; logic [63:0] px, py;
    st_from = 15;
    st_len  = 3;
    capture(50, 0, -1, -1, -1);
    st_len = 0;
    for (int c = 15; c < 18; c++) begin
      n_checks++;
      if (log_q[c].valid !== 1'b0 || log_q[c].h !== 11'd2 || log_q[c].v !== 10'd0) begin
        n_fail++; $display("FAIL stall_hold%0d: got valid=%0b h=%0d v=%0d want 0,2,0", c, log_q[c].valid, log_q[c].h, log_q[c].v);
      end
    end
    exp_lanes(1, st, id, pr, px, py);
    n_checks++;
    if (log_q[18].valid !== 1'b1 || log_q[18].h !== 11'd2 || log_q[18].v !== 10'd0 || log_q[18].px !== px) begin
      n_fail++; $display("FAIL stall_resume: got valid=%0b h=%0d v=%0d px=%h want 1,2,0 px=%h",
                         log_q[18].valid, log_q[18].h, log_q[18].v, log_q[18].px, px);
    end
    n_val = 0;
    for (int c = 0; c < 50; c++) if (log_q[c].valid === 1'b1) n_val++;
    n_checks++;
    if (n_val != 17 || log_q[40].done !== 1'b1) begin
      n_fail++; $display("FAIL stall_totals: got beats=%0d done40=%0b want 17,1", n_val, log_q[40].done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_cache_mapping();
    test_ignore_start();
    test_reset_midframe();
    test_nondivisible();
`ifdef RENDER_SEQ_STALL_EN
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/render_sequencer.md
Name: render_sequencer

Overview:
- Frame-level controller for the 4-wide, two-set object render pipeline.
- On a frame request it loads 8 object records from object storage into a local cache: set A is objects 0-3, set B is objects 4-7.
- It then scans every sampled pixel, issuing two render beats per pixel: set A, then set B, with the same hcount/vcount.
- It drains the render pipeline and reports frame completion.
- Sits between the physics/object-storage side and the render datapath feeding the frame buffer.

Parameters:
- H_PIXELS, 1280: horizontal scan extent in hcount units.
- V_PIXELS, 720: vertical scan extent in vcount units.
- H_STEP, 2: hcount increment per sampled pixel.
- V_STEP, 2: vcount increment per sampled row.
- BASE_ADDR, 0: object storage address of object 0.
- READ_LATENCY, 2: cycles from obj_rd_en to valid obj_data_in.
- DRAIN_CYCLES, 8: cycles waited after the last beat before done (at least the render pipeline depth).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low
- frame_start_in  input  1  one-cycle frame request
- obj_addr_out  output  7  object storage read address
- obj_rd_en_out  output  1  object storage read strobe
- obj_data_in  input  83  object record, packed as {is_static[82], id[81:80], params[79:32], pos_x[31:16], pos_y[15:0]}
- render_rst_out  output  1  active-high reset pulse to the render datapath
- render_valid_out  output  1  beat valid (drives render valid_in)
- is_static_out  output  4  per-slot static flag of current set
- id_bits_out  output  4x2  per-slot shape id of current set
- params_out  output  4x48  per-slot params
- pos_x_out  output  4x16  per-slot x
- pos_y_out  output  4x16  per-slot y
- hcount_out  output  11  pixel column of current beat
- vcount_out  output  10  pixel row of current beat
- busy_out  output  1  high from acceptance of frame_start until frame_done
- frame_done_out  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst_in low at posedge):
  - state IDLE; all outputs 0; cache cleared (all ids 00).
  - Reset mid-frame aborts immediately; no done pulse is issued.
- IDLE:
  - frame_start_in=1 -> LOAD; busy_out=1 next cycle.
  - frame_start_in is ignored in every other state.
- LOAD:
  - Issues 8 reads, one per cycle: obj_addr_out = BASE_ADDR+k, k=0..7, with obj_rd_en_out=1.
  - Captures obj_data_in READ_LATENCY cycles after each strobe into cache slot k.
  - After slot 7 is captured: render_rst_out=1 for exactly one cycle, then SCAN. This forces the render set toggle to start on set A.
  - Cycle count: 8+READ_LATENCY+1.
- SCAN:
  - render_valid_out=1 every cycle (absent stall).
  - Beat phase toggles A,B,A,B...
    - Phase A presents cache slots 0-3.
    - Phase B presents slots 4-7.
    - Slot i maps to lane i of each bus.
  - hcount/vcount are held across the A/B pair.
  - After each B beat: hcount += H_STEP.
  - When hcount+H_STEP >= H_PIXELS: hcount=0 and vcount += V_STEP.
  - When vcount+V_STEP >= V_PIXELS after the last B beat: -> DRAIN.
  - Beats per frame: 2*ceil(H_PIXELS/H_STEP)*ceil(V_PIXELS/V_STEP).
  - Arithmetic is unsigned; comparisons are done in 12 bits to avoid wrap.
- DRAIN:
  - render_valid_out=0.
  - Waits DRAIN_CYCLES, then -> DONE.
  - Note: render advances only on valid, so the final B result emerges only if an extra beat is issued. The sequencer therefore issues one trailing phase-A beat at the last pixel (hcount/vcount held) as the first DRAIN cycle, then deasserts.
- DONE:
  - frame_done_out=1 for one cycle; busy_out=0 the same cycle.
  - -> IDLE.
  - A frame_start_in arriving in the DONE cycle is ignored.
- Object-bus outputs hold their last values when render_valid_out=0.
- hcount_out, vcount_out and the phase counter are 0 outside SCAN/DRAIN.

Optional Feature:
- Macro RENDER_SEQ_STALL_EN.
- When defined:
  - Adds input stall_in (1 bit).
  - In SCAN or in the trailing DRAIN beat, stall_in=1 forces render_valid_out=0 that cycle.
  - hcount, vcount, phase and the drain counter all hold.
  - Scanning resumes at the same beat when stall_in falls.
  - stall_in is ignored in IDLE, LOAD and DONE.
- When not defined: no port exists and scanning is never interrupted.

Test Plan:
- Basic frame (H_PIXELS=8, V_PIXELS=4, steps 2, READ_LATENCY=2), frame_start pulse:
  - Reads addr 0..7.
  - One render_rst_out pulse.
  - 16 scan beats + 1 trailing beat.
  - (h,v) sequence (0,0)A,(0,0)B,(2,0)A ... (6,2)B.
  - frame_done one cycle after DRAIN.
- Cache mapping: obj k loaded with pos_x=0x100+k, id=01:
  - A beats show pos_x lanes 0x100..0x103.
  - B beats show 0x104..0x107.
  - is_static and params match per lane.
- frame_start during SCAN and on the DONE cycle: ignored; exactly one frame_done; busy_out high throughout.
- Reset (rst_in=0) at beat 5:
  - Next cycle all outputs 0, state IDLE.
  - A new frame_start runs a full clean frame starting at (0,0)A.
- Non-divisible extents (H_PIXELS=7, V_PIXELS=3): columns 0,2,4,6, rows 0,2; 16 scan beats; no hcount ≥7 emitted.
- RENDER_SEQ_STALL_EN, stall_in high for 3 cycles starting on a B beat:
  - render_valid_out low for 3 cycles.
  - Resumes with the same B beat at the same (h,v).
  - Total valid beats unchanged (17).
